// File: rtl/wvb_rd_sched.sv
// Purpose : round-robin readout scheduler; grants one non-empty waveform-buffer
//           channel at a time and streams exactly one event of samples downstream.
// Latency : hdr_rdreq -> first wvb_rdreq = HDR_WAIT_CNT+1 cycles; wvb_rdreq -> dout_valid = P_RD_LAT cycles.
// Backpr. : dout_rdy low stalls wvb_rdreq with no penalty; words already in the RAM
//           pipeline still drain, so dout_rdy must promise room for P_RD_LAT+1 words.
//
// Ports
//   clk, rst            : clock; asynchronous active-high reset
//   en                  : permit new grants (an event in progress always completes)
//   hdr_empty[N]        : per-channel header FIFO empty
//   start/stop_addr_flat: per-channel header addresses, channel c at [c*W +: W]
//   dout_rdy            : downstream can take P_RD_LAT+1 more words
//   hdr_rdreq[N]        : one-hot, one-cycle header read strobe
//   wvb_rdreq[N]        : one-hot, per-sample read strobe
//   wvb_rddone[N]       : one-hot, one-cycle end-of-event strobe
//   dout_valid/sop/eop  : sample present / first / last of event
//   dout_chan           : channel of the sample on dout
//   busy                : scheduler not idle
module wvb_rd_sched #(
  parameter int N_CHAN       = 4,
  parameter int P_ADR_WIDTH  = 12,
  parameter int HDR_WAIT_CNT = 2,
  parameter int P_RD_LAT     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [N_CHAN-1:0]             hdr_empty,
  input  logic [N_CHAN*P_ADR_WIDTH-1:0] start_addr_flat,
  input  logic [N_CHAN*P_ADR_WIDTH-1:0] stop_addr_flat,
  input  logic                          dout_rdy,
  output logic [N_CHAN-1:0]             hdr_rdreq,
  output logic [N_CHAN-1:0]             wvb_rdreq,
  output logic [N_CHAN-1:0]             wvb_rddone,
  output logic                          dout_valid,
  output logic                          dout_sop,
  output logic                          dout_eop,
  output logic [$clog2(N_CHAN)-1:0]     dout_chan,
  output logic                          busy
);

  localparam int CW  = $clog2(N_CHAN);
  localparam int RW  = P_ADR_WIDTH + 1;
  localparam int WCW = (HDR_WAIT_CNT > 1) ? $clog2(HDR_WAIT_CNT) : 1;
  localparam logic [N_CHAN-1:0] CHAN_ONE = N_CHAN'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HDR_RD   = 3'd1,
    S_HDR_WAIT = 3'd2,
    S_STREAM   = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       sel_q, sel_d;
  logic [CW-1:0]       last_grant_q, last_grant_d;
  logic [WCW-1:0]      wait_cnt_q, wait_cnt_d;
  logic [RW-1:0]       remaining_q, remaining_d;
  logic                first_q, first_d;

  // Read-data pipeline mirroring the RAM read latency; stage 0 is fed by the strobe.
  logic [P_RD_LAT-1:0]         pipe_vld_q, pipe_vld_d;
  logic [P_RD_LAT-1:0]         pipe_sop_q, pipe_sop_d;
  logic [P_RD_LAT-1:0]         pipe_eop_q, pipe_eop_d;
  logic [P_RD_LAT-1:0][CW-1:0] pipe_chan_q, pipe_chan_d;

  logic [P_ADR_WIDTH-1:0] start_addr [N_CHAN];
  logic [P_ADR_WIDTH-1:0] stop_addr  [N_CHAN];
  logic [P_ADR_WIDTH-1:0] span;
  logic                   any_req;
  logic [CW-1:0]          rr_pick;
  logic [CW-1:0]          rr_cand;
  int                     rr_j;
  logic                   rd_stb;
  logic [N_CHAN-1:0]      sel_oh;

  for (genvar c = 0; c < N_CHAN; c++) begin : g_unpack
    assign start_addr[c] = start_addr_flat[c*P_ADR_WIDTH +: P_ADR_WIDTH];
    assign stop_addr[c]  = stop_addr_flat[c*P_ADR_WIDTH +: P_ADR_WIDTH];
  end

  assign any_req = ~&hdr_empty;

  // Round-robin search starting at last_grant+1. Offsets are scanned from the
  // farthest to the nearest so the nearest non-empty channel is the last write.
  always_comb begin
    rr_pick = last_grant_q;
    rr_cand = '0;
    rr_j    = 0;
    for (int i = N_CHAN; i >= 1; i--) begin
      rr_j    = (int'(last_grant_q) + i) % N_CHAN;
      rr_cand = CW'(rr_j);
      if (!hdr_empty[rr_cand]) begin
        rr_pick = rr_cand;
      end
    end
  end

  // Event length in words, modulo the buffer size so wrapped events count
  // correctly; an event with start == stop is one word.
  assign span = stop_addr[sel_q] - start_addr[sel_q];

  // Strobe is combinational from registered state so a dout_rdy drop takes
  // effect in the same cycle.
  assign rd_stb = (state_q == S_STREAM) && dout_rdy && (remaining_q != '0);

  assign sel_oh = CHAN_ONE << sel_q;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    remaining_d  = remaining_q;
    first_d      = first_q;

    case (state_q)
      S_IDLE: begin
        if (en && any_req) begin
          sel_d   = rr_pick;
          state_d = S_HDR_RD;
        end
      end

      S_HDR_RD: begin
        last_grant_d = sel_q;
        wait_cnt_d   = '0;
        state_d      = S_HDR_WAIT;
      end

      S_HDR_WAIT: begin
        // Header fields become valid only on the last wait cycle, so the
        // length is captured there and nowhere earlier.
        if (wait_cnt_q == WCW'(HDR_WAIT_CNT - 1)) begin
          remaining_d = {1'b0, span} + RW'(1);
          first_d     = 1'b1;
          state_d     = S_STREAM;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end

      S_STREAM: begin
        if (rd_stb) begin
          remaining_d = remaining_q - RW'(1);
          first_d     = 1'b0;
          if (remaining_q == RW'(1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    pipe_vld_d  = '0;
    pipe_sop_d  = '0;
    pipe_eop_d  = '0;
    pipe_chan_d = '0;

    pipe_vld_d[0]  = rd_stb;
    pipe_sop_d[0]  = rd_stb && first_q;
    pipe_eop_d[0]  = rd_stb && (remaining_q == RW'(1));
    pipe_chan_d[0] = sel_q;

    for (int s = 1; s < P_RD_LAT; s++) begin
      pipe_vld_d[s]  = pipe_vld_q[s-1];
      pipe_sop_d[s]  = pipe_sop_q[s-1];
      pipe_eop_d[s]  = pipe_eop_q[s-1];
      pipe_chan_d[s] = pipe_chan_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      // Channel 0 gets first priority after reset.
      last_grant_q <= CW'(N_CHAN - 1);
      wait_cnt_q   <= '0;
      remaining_q  <= '0;
      first_q      <= 1'b0;
      pipe_vld_q   <= '0;
      pipe_sop_q   <= '0;
      pipe_eop_q   <= '0;
      pipe_chan_q  <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      remaining_q  <= remaining_d;
      first_q      <= first_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_sop_q   <= pipe_sop_d;
      pipe_eop_q   <= pipe_eop_d;
      pipe_chan_q  <= pipe_chan_d;
    end
  end

  assign hdr_rdreq  = (state_q == S_HDR_RD) ? sel_oh : '0;
  assign wvb_rdreq  = rd_stb                ? sel_oh : '0;
  assign wvb_rddone = (state_q == S_DONE)   ? sel_oh : '0;

  assign dout_valid = pipe_vld_q[P_RD_LAT-1];
  assign dout_sop   = pipe_sop_q[P_RD_LAT-1];
  assign dout_eop   = pipe_eop_q[P_RD_LAT-1];
  assign dout_chan  = pipe_chan_q[P_RD_LAT-1];

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_wvb_rd_sched.sv
// Purpose : directed self-checking bench for wvb_rd_sched (4 channels, 12-bit addresses).
// Latency : expected cycle offsets are hand-derived from hdr_rdreq (HDR_WAIT_CNT=2, P_RD_LAT=2).
// Backpr. : dout_rdy is driven low pseudo-randomly in one scenario; strobes under low rdy are errors.
module tb_wvb_rd_sched;
  localparam int N = 4;
  localparam int W = 12;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en  = 1'b0;
  logic           dout_rdy = 1'b1;
  logic [N-1:0]   hdr_empty = '1;
  logic [N*W-1:0] start_flat = '0;
  logic [N*W-1:0] stop_flat  = '0;

  logic [N-1:0]   hdr_rdreq, wvb_rdreq, wvb_rddone;
  logic           dout_valid, dout_sop, dout_eop, busy;
  logic [1:0]     dout_chan;

  wvb_rd_sched #(
    .N_CHAN(N), .P_ADR_WIDTH(W), .HDR_WAIT_CNT(2), .P_RD_LAT(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .hdr_empty(hdr_empty),
    .start_addr_flat(start_flat), .stop_addr_flat(stop_flat),
    .dout_rdy(dout_rdy), .hdr_rdreq(hdr_rdreq), .wvb_rdreq(wvb_rdreq),
    .wvb_rddone(wvb_rddone), .dout_valid(dout_valid), .dout_sop(dout_sop),
    .dout_eop(dout_eop), .dout_chan(dout_chan), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log, written only by the monitor.
  int hdr_cyc[$], hdr_ch[$], rd_cyc[$], rd_ch[$], done_cyc[$], done_ch[$];
  int vld_cyc[$], vld_ch[$], sop_cyc[$], eop_cyc[$];
  int n_multi  = 0;
  int n_norrdy = 0;

  int n_checks = 0;
  int n_errors = 0;
  int hb, rb, db, vb, sb, eb, nb, t;

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    if ($countones(hdr_rdreq) > 1 || $countones(wvb_rdreq) > 1 || $countones(wvb_rddone) > 1)
      n_multi <= n_multi + 1;
    if (hdr_rdreq != '0) begin
      hdr_cyc.push_back(cyc);
      hdr_ch.push_back(oh_idx(hdr_rdreq));
    end
    if (wvb_rdreq != '0) begin
      rd_cyc.push_back(cyc);
      rd_ch.push_back(oh_idx(wvb_rdreq));
      if (!dout_rdy) n_norrdy <= n_norrdy + 1;
    end
    if (wvb_rddone != '0) begin
      done_cyc.push_back(cyc);
      done_ch.push_back(oh_idx(wvb_rddone));
    end
    if (dout_valid) begin
      vld_cyc.push_back(cyc);
      vld_ch.push_back(int'(dout_chan));
      if (dout_sop) sop_cyc.push_back(cyc);
      if (dout_eop) eop_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    hb = hdr_cyc.size(); rb = rd_cyc.size(); db = done_cyc.size();
    vb = vld_cyc.size(); sb = sop_cyc.size(); eb = eop_cyc.size();
    nb = n_norrdy;
  endtask

  task automatic wait_hdr(input int target);
    int k;
    k = 0;
    while (hdr_cyc.size() < target && k < 300) begin step(); k++; end
    check("hdr_seen", hdr_cyc.size(), target);
  endtask

  task automatic wait_rd(input int target);
    int k;
    k = 0;
    while (rd_cyc.size() < target && k < 300) begin step(); k++; end
    check("rd_seen", rd_cyc.size(), target);
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_cyc.size() < target && k < 400) begin step(); k++; end
    check("done_seen", done_cyc.size(), target);
  endtask

  task automatic set_addr(input int ch, input logic [W-1:0] s, input logic [W-1:0] e);
    start_flat[ch*W +: W] = s;
    stop_flat[ch*W +: W]  = e;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  // One event: present the mask until the header read is seen, then empty all.
  task automatic run_event(input logic [N-1:0] empty, input bit rnd_rdy);
    int k;
    k = 0;
    hdr_empty = empty;
    while (done_cyc.size() <= db && k < 400) begin
      if (hdr_cyc.size() > hb) hdr_empty = '1;
      if (rnd_rdy) dout_rdy = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    check("evt_done", done_cyc.size() - db, 1);
    dout_rdy  = 1'b1;
    hdr_empty = '1;
    repeat (6) step();
  endtask

  int rr1[5] = '{0, 1, 2, 3, 0};
  int rr2[4] = '{0, 2, 3, 0};

  initial begin
    // Reset state
    #1 rst = 1'b1;
    repeat (3) step();
    check("rst_outs", int'({hdr_rdreq, wvb_rdreq, wvb_rddone, dout_valid, dout_sop, dout_eop, dout_chan, busy}), 0);
    rst = 1'b0;
    en  = 1'b1;
    repeat (2) step();
    check("idle_busy", int'(busy), 0);

    // Single 4-word event on channel 0
    set_addr(0, 12'h010, 12'h013);
    snap();
    run_event(4'b1110, 1'b0);
    t = hdr_cyc[hb];
    check("se_hdr_ch",   hdr_ch[hb], 0);
    check("se_rd_cnt",   rd_cyc.size() - rb, 4);
    check("se_rd_first", rd_cyc[rb], t + 3);
    check("se_rd_last",  rd_cyc[rb+3], t + 6);
    check("se_rd_ch",    rd_ch[rb], 0);
    check("se_done",     done_cyc[db], t + 7);
    check("se_done_ch",  done_ch[db], 0);
    check("se_vld_cnt",  vld_cyc.size() - vb, 4);
    check("se_vld_first", vld_cyc[vb], t + 5);
    check("se_vld_last", vld_cyc[vb+3], t + 8);
    check("se_sop_cnt",  sop_cyc.size() - sb, 1);
    check("se_sop",      sop_cyc[sb], t + 5);
    check("se_eop_cnt",  eop_cyc.size() - eb, 1);
    check("se_eop",      eop_cyc[eb], t + 8);
    check("se_chan",     vld_ch[vb+3], 0);

    // Wrapped event on channel 1: 0xFFE..0x001 is 4 words
    set_addr(1, 12'hFFE, 12'h001);
    snap();
    run_event(4'b1101, 1'b0);
    check("wr_hdr_ch",  hdr_ch[hb], 1);
    check("wr_rd_cnt",  rd_cyc.size() - rb, 4);
    check("wr_vld_cnt", vld_cyc.size() - vb, 4);
    check("wr_chan",    vld_ch[vb], 1);
    check("wr_sop_cnt", sop_cyc.size() - sb, 1);
    check("wr_eop_gap", eop_cyc[eb] - sop_cyc[sb], 3);

    // start == stop on channel 2: single word, sop and eop together
    set_addr(2, 12'h123, 12'h123);
    snap();
    run_event(4'b1011, 1'b0);
    t = hdr_cyc[hb];
    check("one_rd_cnt",  rd_cyc.size() - rb, 1);
    check("one_rd_cyc",  rd_cyc[rb], t + 3);
    check("one_done",    done_cyc[db], t + 4);
    check("one_vld_cnt", vld_cyc.size() - vb, 1);
    check("one_vld_cyc", vld_cyc[vb], t + 5);
    check("one_sop",     sop_cyc[sb], t + 5);
    check("one_eop",     eop_cyc[eb], t + 5);
    check("one_chan",    vld_ch[vb], 2);

    // Round robin, all non-empty, 2-word events
    for (int c = 0; c < N; c++) set_addr(c, 12'h100, 12'h101);
    do_reset();
    snap();
    hdr_empty = '0;
    wait_hdr(hb + 5);
    hdr_empty = '1;
    wait_done(db + 5);
    repeat (6) step();
    for (int i = 0; i < 5; i++) check("rr_order", hdr_ch[hb+i], rr1[i]);
    check("rr_period",  hdr_cyc[hb+1] - hdr_cyc[hb], 7);
    check("rr_idle_gap", hdr_cyc[hb+1] - done_cyc[db], 2);
    check("rr_rd_cnt",  rd_cyc.size() - rb, 10);

    // Round robin with channel 1 empty
    do_reset();
    snap();
    hdr_empty = 4'b0010;
    wait_hdr(hb + 4);
    hdr_empty = '1;
    wait_done(db + 4);
    repeat (6) step();
    for (int i = 0; i < 4; i++) check("rr_skip_order", hdr_ch[hb+i], rr2[i]);

    // Backpressure: 8-word event on channel 3 with random dout_rdy
    set_addr(3, 12'h200, 12'h207);
    snap();
    run_event(4'b0111, 1'b1);
    check("bp_hdr_ch",  hdr_ch[hb], 3);
    check("bp_rd_cnt",  rd_cyc.size() - rb, 8);
    check("bp_norrdy",  n_norrdy - nb, 0);
    check("bp_vld_cnt", vld_cyc.size() - vb, 8);
    check("bp_sop_cnt", sop_cyc.size() - sb, 1);
    check("bp_eop_cnt", eop_cyc.size() - eb, 1);

    // Enable dropped mid-stream: event completes, no new grants
    for (int c = 0; c < N; c++) set_addr(c, 12'h000, 12'h009);
    snap();
    hdr_empty = '0;
    en = 1'b1;
    wait_hdr(hb + 1);
    wait_rd(rb + 2);
    en = 1'b0;
    wait_done(db + 1);
    repeat (30) step();
    check("en_hdr_cnt",  hdr_cyc.size() - hb, 1);
    check("en_done_cnt", done_cyc.size() - db, 1);
    check("en_rd_cnt",   rd_cyc.size() - rb, 10);
    check("en_busy",     int'(busy), 0);
    hdr_empty = '1;
    en = 1'b1;
    step();

    // Reset after 3 of 10 strobes on channel 2
    set_addr(2, 12'h300, 12'h309);
    snap();
    hdr_empty = 4'b1011;
    wait_hdr(hb + 1);
    hdr_empty = '1;
    wait_rd(rb + 3);
    rst = 1'b1;
    #1;
    check("mid_rst_outs", int'({hdr_rdreq, wvb_rdreq, wvb_rddone, dout_valid, dout_sop, dout_eop, dout_chan, busy}), 0);
    hdr_empty = '0;
    repeat (3) step();
    check("mid_rst_rd",   rd_cyc.size() - rb, 3);
    check("mid_rst_done", done_cyc.size() - db, 0);
    check("mid_rst_hdr",  hdr_cyc.size() - hb, 1);
    rst = 1'b0;
    wait_hdr(hb + 2);
    hdr_empty = '1;
    check("mid_rst_grant", hdr_ch[hb+1], 0);
    wait_done(db + 1);
    repeat (6) step();

    check("onehot", n_multi, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wvb_rd_sched.md
# wvb_rd_sched

Round-robin readout scheduler for the mDOM waveform buffers. It picks one channel at a time whose header FIFO is non-empty and drives that channel's `hdr_rdreq`, `wvb_rdreq` and `wvb_rddone` strobes into its per-channel read-address controller. It streams exactly one event's worth of samples to the shared downstream packer, with backpressure. It sits between the N per-channel waveform buffers and the single readout/packer path.

## Interface
- `N_CHAN`, 4: number of waveform-buffer channels (2..16).
- `P_ADR_WIDTH`, 12: waveform-buffer address width.
- `HDR_WAIT_CNT`, 2: cycles from `hdr_rdreq` until header fields are valid; must match the read-address controller.
- `P_RD_LAT`, 2: waveform RAM read latency, in cycles from `wvb_rdreq` to the sample at the output.
- `clk`  in  1: the single clock.
- `rst`  in  1: reset, asynchronous and active-high.
- `en`  in  1: allow new grants.
- `hdr_empty`  in  N_CHAN: per-channel header FIFO empty.
- `start_addr_flat`  in  N_CHAN*P_ADR_WIDTH: per-channel header start address. Channel c occupies bits [c*W +: W].
- `stop_addr_flat`  in  N_CHAN*P_ADR_WIDTH: per-channel header stop address, same packing.
- `dout_rdy`  in  1: downstream can accept P_RD_LAT+1 more words.
- `hdr_rdreq`  out  N_CHAN: one-hot, one-cycle header read strobe.
- `wvb_rdreq`  out  N_CHAN: one-hot, per-sample read strobe.
- `wvb_rddone`  out  N_CHAN: one-hot, one-cycle end-of-event strobe.
- `dout_valid`  out  1: a sample is present at the downstream.
- `dout_sop`  out  1: first sample of an event; qualified by `dout_valid`.
- `dout_eop`  out  1: last sample of an event; qualified by `dout_valid`.
- `dout_chan`  out  clog2(N_CHAN): channel of the current sample.
- `busy`  out  1: the state machine is not in IDLE.

## Operation
- State machine: IDLE → HDR_RD → HDR_WAIT → STREAM → DONE → IDLE.
- **IDLE**
  - If `en` is high and any `hdr_empty` bit is low, grant the first non-empty channel searching upward from `last_grant+1`, wrapping modulo N_CHAN.
  - Register the grant as `sel`, then go to HDR_RD.
- **HDR_RD**
  - Assert `hdr_rdreq[sel]` for exactly 1 cycle.
  - Go to HDR_WAIT and set `last_grant` to `sel`.
- **HDR_WAIT**
  - Lasts HDR_WAIT_CNT cycles.
  - On the last cycle, latch `start_addr[sel]` and `stop_addr[sel]`.
  - Load `remaining` = ((stop − start) mod 2^P_ADR_WIDTH) + 1.
  - `remaining` is P_ADR_WIDTH+1 bits wide, range 1..2^P_ADR_WIDTH. start == stop gives 1; start > stop means the event wraps around the buffer.
- **STREAM**
  - `wvb_rdreq[sel]` = STREAM & `dout_rdy` & (`remaining` ≠ 0). It is combinational from registered state.
  - Each strobe decrements `remaining`.
  - When the last strobe is issued, go to DONE.
- **DONE**
  - Assert `wvb_rddone[sel]` for 1 cycle, then go to IDLE.
- **Output pipeline** (P_RD_LAT stages deep)
  - Each `wvb_rdreq` pushes {valid, sop = first strobe of the event, eop = last strobe, `sel`}.
  - `dout_*` are the pipeline outputs. `dout_valid` is high exactly P_RD_LAT cycles after each strobe.
- **Enable:** `en` low blocks grants only. An event already in progress runs through DONE.
- **Header changes:** `hdr_empty` changing after the grant is ignored until the scheduler returns to IDLE.
- **Reset** (async, usable mid-event)
  - State returns to IDLE and `last_grant` to N_CHAN−1, so channel 0 has first priority.
  - `remaining`, `sel` and the pipeline clear.
  - All outputs go to 0. `wvb_rddone` is not issued for an aborted event.

## Timing
- If `hdr_rdreq` is high in cycle t:
  - `wvb_rdreq` is suppressed in t+1 .. t+HDR_WAIT_CNT.
  - The first `wvb_rdreq` is possible at t+HDR_WAIT_CNT+1, when the address controller has loaded start.
- Grant at the IDLE edge; `hdr_rdreq` appears in the following cycle.
- `wvb_rddone` comes 1 cycle after the last `wvb_rdreq`.
- The next `hdr_rdreq` comes no earlier than 2 cycles after `wvb_rddone` (one IDLE cycle).
- No-backpressure event of L words: hdr_rdreq→rddone = HDR_WAIT_CNT+L+1 cycles.
- `dout_rdy` low stalls strobes with no penalty. The `remaining` count is exact regardless of how `dout_rdy` toggles.
- At most one bit of each of `hdr_rdreq`, `wvb_rdreq` and `wvb_rddone` is ever high.

## Test plan
- **Single event:** ch0 with start 0x010, stop 0x013, `hdr_rdreq[0]` at t.
  - `wvb_rdreq[0]` is high t+3..t+6, four strobes.
  - `wvb_rddone[0]` at t+7.
  - `dout_valid` t+5..t+8, with sop at t+5, eop at t+8, `dout_chan` = 0.
- **Wrap-around:** start 0xFFE, stop 0x001 gives exactly 4 strobes. start = stop = 0x123 gives 1 strobe with sop and eop both high.
- **Round robin:** all 4 channels non-empty, each event 2 words, after reset.
  - Grant order is 0,1,2,3,0.
  - Repeat with ch1 empty: order is 0,2,3,0.
- **Backpressure:** 8-word event, `dout_rdy` toggled pseudo-randomly.
  - Exactly 8 strobes, never issued while `dout_rdy` is low.
  - 8 `dout_valid` pulses with single sop and eop.
- **Enable:** `en` dropped during STREAM.
  - The event completes with `wvb_rddone`.
  - No further `hdr_rdreq` while `en` = 0, even with FIFOs non-empty.
- **Reset mid-stream:** `rst` pulsed after 3 of 10 strobes.
  - All outputs go to 0 immediately, with no `wvb_rddone`.
  - After release, the first grant goes to channel 0.
